// File: rtl/port_bridge.sv
// Host-side bridge for the CPU's 32-bit nibble port: byte streams in both directions,
// moved across the port with toggle handshakes and buffered by small FIFOs.

module port_bridge_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        do_push, do_pop;

  // Extra MSB on each pointer tells full (MSB differs) from empty (all equal).
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = empty_o ? 8'h00 : mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + (AW+1)'(1);
    if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

module port_bridge #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [31:0] port_in,
  input  logic [31:0] port_out
);
  typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK} state_t;

  state_t     state_q, state_d;
  logic [7:0] tx_dat_q, tx_dat_d;
  logic       tx_req_q, tx_req_d;
  logic       rx_ack_q, rx_ack_d;
  logic [9:0] sync_m_q, sync_s_q;
  logic       req_s, ack_s;
  logic [7:0] dat_s;
  logic       tx_pop, tx_full, tx_empty;
  logic [7:0] tx_head;
  logic       rx_push, rx_full, rx_empty;
  logic       unused_port_bits;

  assign unused_port_bits = ^{port_out[31:13], port_out[11:9]};

  // port_out is asynchronous; only the request, ack and data bits are brought across.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_m_q <= '0;
      sync_s_q <= '0;
    end else begin
      sync_m_q <= {port_out[12], port_out[8], port_out[7:0]};
      sync_s_q <= sync_m_q;
    end
  end

  assign req_s = sync_s_q[9];
  assign ack_s = sync_s_q[8];
  assign dat_s = sync_s_q[7:0];

  port_bridge_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_valid),
    .pop_i   (tx_pop),
    .wdata_i (tx_data),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  port_bridge_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push),
    .pop_i   (rx_ready),
    .wdata_i (dat_s),
    .rdata_o (rx_data),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  // Data is loaded one cycle before the toggle so the CPU never sees a half-updated byte.
  always_comb begin
    state_d  = state_q;
    tx_dat_d = tx_dat_q;
    tx_req_d = tx_req_q;
    tx_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!tx_empty) begin
          tx_pop   = 1'b1;
          tx_dat_d = tx_head;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        tx_req_d = ~tx_req_q;
        state_d  = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_s == tx_req_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A pending CPU request is left unacknowledged while the RX FIFO is full.
  assign rx_push  = (req_s != rx_ack_q) && !rx_full;
  assign rx_ack_d = rx_ack_q ^ rx_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tx_dat_q <= '0;
      tx_req_q <= 1'b0;
      rx_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_dat_q <= tx_dat_d;
      tx_req_q <= tx_req_d;
      rx_ack_q <= rx_ack_d;
    end
  end

  assign port_in  = {19'b0, rx_ack_q, 3'b0, tx_req_q, tx_dat_q};
  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;
endmodule

// File: tb/tb_port_bridge.sv
// Bench for port_bridge: queue-level bridge model, a CPU software model on port_out,
// and a host driver; everything runs in one sequential process per clock.

module tb_port_bridge;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] port_in;
  logic [31:0] port_out;

  always #5 clk = ~clk;

  port_bridge #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .port_in  (port_in),
    .port_out (port_out)
  );

  int checks = 0;
  int errors = 0;

  // bridge model: FIFO contents as queues, port word as plain fields
  logic [7:0]  m_txq[$];
  logic [7:0]  m_rxq[$];
  logic [31:0] m_dly[2];
  bit          m_busy, m_tog_pend, m_req, m_ack, model_on;
  logic [7:0]  m_dat;

  // CPU software model
  logic        cpu_rst;
  int          cpu_slow, cpu_cnt, cpu_phase;
  bit          cpu_jit;
  logic [7:0]  cpu_send[$];
  logic [7:0]  cpu_got[$];

  // host side
  logic [7:0]  host_src[$];
  logic [7:0]  host_sent[$];
  logic [7:0]  host_got[$];
  logic [7:0]  rx_exp[$];
  int          p_tx, rx_mode, tog_cnt, acc_at_drop;
  bit          force_valid;
  logic        last_ack12;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [31:0] s;
    bit tx_push, rx_push, rx_pop;
    if (rst) begin
      m_txq.delete(); m_rxq.delete();
      m_dly[0] = '0; m_dly[1] = '0;
      m_busy = 0; m_tog_pend = 0; m_req = 0; m_ack = 0; m_dat = '0;
      model_on = 1;
    end else begin
      s       = m_dly[1];
      tx_push = tx_valid && (m_txq.size() < DEPTH);
      rx_push = (s[12] != m_ack) && (m_rxq.size() < DEPTH);
      rx_pop  = rx_ready && (m_rxq.size() > 0);
      if (!m_busy && m_txq.size() > 0) begin
        m_dat = m_txq.pop_front(); m_busy = 1; m_tog_pend = 1;
      end else if (m_tog_pend) begin
        m_req = ~m_req; m_tog_pend = 0;
      end else if (m_busy && s[8] == m_req) begin
        m_busy = 0;
      end
      if (tx_push) m_txq.push_back(tx_data);
      if (rx_pop) void'(m_rxq.pop_front());
      if (rx_push) begin m_rxq.push_back(s[7:0]); m_ack = ~m_ack; end
      m_dly[1] = m_dly[0];
      m_dly[0] = port_out;
    end
  endtask

  task automatic cpu_tick();
    if (cpu_rst) begin
      port_out = '0; cpu_phase = 0; cpu_cnt = cpu_slow;
    end else begin
      if (port_in[8] != port_out[8]) begin
        if (cpu_cnt <= 0) begin
          cpu_got.push_back(port_in[7:0]);
          port_out[8] = port_in[8];
          cpu_cnt = cpu_jit ? int'($urandom_range(cpu_slow, 0)) : cpu_slow;
        end else cpu_cnt--;
      end
      case (cpu_phase)
        0: if (cpu_send.size() > 0 && port_in[12] == port_out[12]) begin
             port_out[7:0] = cpu_send[0]; cpu_phase = 1;
           end
        1: begin port_out[12] = ~port_out[12]; void'(cpu_send.pop_front()); cpu_phase = 2; end
        default: if (port_in[12] == port_out[12]) cpu_phase = 0;
      endcase
      port_out[31:13] = 19'($urandom);
      port_out[11:9]  = 3'($urandom);
    end
  endtask

  task automatic compare();
    if (model_on) begin
      chk("port_in", port_in, {19'b0, m_ack, 3'b0, m_req, m_dat});
      chk("tx_ready", 32'(tx_ready), 32'(m_txq.size() < DEPTH));
      chk("rx_valid", 32'(rx_valid), 32'(m_rxq.size() > 0));
      chk("rx_data", 32'(rx_data), (m_rxq.size() > 0) ? 32'(m_rxq[0]) : 32'h0);
    end
  endtask

  task automatic host_drive();
    if (port_in[12] !== last_ack12) tog_cnt++;
    last_ack12 = port_in[12];
    if (force_valid) begin
      tx_valid = 1'b1; tx_data = 8'h55;
    end else if (host_src.size() > 0 && $urandom_range(99, 0) < p_tx) begin
      tx_valid = 1'b1; tx_data = host_src[0];
      if (tx_ready) begin host_sent.push_back(tx_data); void'(host_src.pop_front()); end
    end else begin
      tx_valid = 1'b0; tx_data = 8'($urandom);
    end
    rx_ready = (rx_mode == 0) ? 1'b0 : (rx_mode == 1) ? 1'b1 : 1'($urandom_range(1, 0));
    if (rx_ready && rx_valid) host_got.push_back(rx_data);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #2;
    cpu_tick();
    @(negedge clk);
    compare();
    host_drive();
  endtask

  task automatic chk_seq(input string name, input logic [7:0] got[$], input logic [7:0] exp[$]);
    chk({name, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk(name, (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(exp[i]));
  endtask

  initial begin
    logic [7:0] exp_q[$];
    rst = 1; cpu_rst = 1; force_valid = 1; tx_valid = 1; tx_data = 8'h55; rx_ready = 0;
    port_out = '0; p_tx = 0; rx_mode = 0; cpu_slow = 0; cpu_jit = 0; cpu_cnt = 0;
    cpu_phase = 0; model_on = 0; tog_cnt = 0; last_ack12 = 0;

    // reset held two cycles with tx_valid high
    step(); step();
    chk("rst_port_in", port_in, 32'h0);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_tx_ready", 32'(tx_ready), 32'h1);
    rst = 0; cpu_rst = 0; force_valid = 0; tx_valid = 0;
    repeat (3) step();
    chk("post_rst_port_in", port_in, 32'h0);

    // single byte: data at N+1, toggle at N+2
    host_src.push_back(8'hA5); p_tx = 100;
    step();
    chk("tx1_accepted", 32'(host_sent.size()), 32'h1);
    step();
    step();
    chk("tx1_data_n1", 32'(port_in[7:0]), 32'hA5);
    chk("tx1_req_n1", 32'(port_in[8]), 32'h0);
    step();
    chk("tx1_req_n2", 32'(port_in[8]), 32'h1);
    repeat (6) step();
    chk("tx1_req_hold", 32'(port_in[8]), 32'h1);
    exp_q = {8'hA5};
    chk_seq("tx1_cpu", cpu_got, exp_q);

    // burst against a slow CPU: 4 in FIFO + 1 on the port before tx_ready drops
    host_sent.delete(); cpu_got.delete();
    cpu_slow = 20; cpu_cnt = 20; acc_at_drop = -1;
    for (int i = 1; i <= 6; i++) host_src.push_back(8'(i));
    for (int i = 0; i < 30 && acc_at_drop < 0; i++) begin
      step();
      if (!tx_ready) acc_at_drop = host_sent.size();
    end
    chk("burst_accepted_at_full", 32'(acc_at_drop), 32'd5);
    for (int i = 0; i < 400 && cpu_got.size() < 6; i++) step();
    exp_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    chk_seq("burst_cpu", cpu_got, exp_q);

    // RX with the host stalled: four acks then the CPU stalls
    cpu_slow = 0; cpu_cnt = 0; rx_mode = 0; repeat (5) step();
    tog_cnt = 0;
    for (int i = 0; i < 6; i++) cpu_send.push_back(8'h10 + 8'(i));
    repeat (40) step();
    chk("rxbp_toggles", 32'(tog_cnt), 32'd4);
    chk("rxbp_cpu_left", 32'(cpu_send.size()), 32'd1);
    chk("rxbp_host_got", 32'(host_got.size()), 32'd0);
    rx_mode = 1;
    for (int i = 0; i < 200 && host_got.size() < 6; i++) step();
    repeat (10) step();
    exp_q = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    chk_seq("rxbp_host", host_got, exp_q);

    // random concurrent traffic in both directions
    host_sent.delete(); cpu_got.delete(); host_got.delete(); rx_exp.delete();
    for (int i = 0; i < 48; i++) begin
      host_src.push_back(8'($urandom));
      cpu_send.push_back(8'($urandom));
      rx_exp.push_back(cpu_send[i]);
    end
    p_tx = 60; rx_mode = 2; cpu_slow = 2; cpu_jit = 1;
    for (int i = 0; i < 3000 && (cpu_got.size() < 48 || host_got.size() < 48); i++) step();
    chk_seq("mix_tx", cpu_got, host_sent);
    chk("mix_tx_all_sent", 32'(host_sent.size()), 32'd48);
    chk_seq("mix_rx", host_got, rx_exp);
    repeat (10) step();

    // reset while a byte waits for its ack and two more are queued
    host_sent.delete(); cpu_got.delete();
    cpu_jit = 0; cpu_slow = 30; cpu_cnt = 30; p_tx = 100; rx_mode = 1;
    host_src = {8'hA1, 8'hA2, 8'hA3};
    repeat (8) step();
    chk("mid_port_dat", 32'(port_in[7:0]), 32'hA1);
    chk("mid_accepted", 32'(host_sent.size()), 32'd3);
    chk("mid_cpu_none", 32'(cpu_got.size()), 32'd0);
    rst = 1; cpu_rst = 1; p_tx = 0;
    repeat (2) step();
    chk("mid_rst_port_in", port_in, 32'h0);
    chk("mid_rst_tx_ready", 32'(tx_ready), 32'h1);
    chk("mid_rst_rx_valid", 32'(rx_valid), 32'h0);
    rst = 0; cpu_rst = 0; cpu_slow = 0; cpu_cnt = 0;
    host_sent.delete(); cpu_got.delete();
    host_src.push_back(8'h3C); p_tx = 100;
    for (int i = 0; i < 50 && cpu_got.size() < 1; i++) step();
    repeat (10) step();
    exp_q = {8'h3C};
    chk_seq("mid_after", cpu_got, exp_q);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/port_bridge.md
# port_bridge

Host-side end of the CPU's 32-bit nibble port interface. The bridge turns two byte streams into the CPU's port protocol: a valid/ready stream from the host (TX) and a valid/ready stream to the host (RX). It drives the CPU's `port_in` and samples the CPU's `port_out`, using toggle handshakes so that nibble-by-nibble CPU software can move one byte per transaction in each direction. Each direction is buffered by a DEPTH-entry FIFO.

## Interface
Parameters:
- DEPTH, 4: entries per FIFO. Must be a power of two and at least 2.

Ports:
- clk  in  1  bridge clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  8  byte from the host, bound for the CPU.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  TX FIFO can accept a byte (not full).
- rx_data  out  8  byte from the CPU, bound for the host; this is the RX FIFO head.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  host consumes rx_data.
- port_in  out  32  registered; connects to the CPU `port_in`.
- port_out  in  32  connects to the CPU `port_out`; asynchronous to clk.

## Operation
Port bit map:
- Host to CPU: port_in[7:0] carries the byte, port_in[8] is the request toggle (tx_req), and port_out[8] is the CPU's acknowledge toggle.
- CPU to host: port_out[7:0] carries the byte, port_out[12] is the CPU request toggle, and port_in[12] is the bridge acknowledge toggle (rx_ack).
- All other port_in bits are driven 0 at all times. All other port_out bits are ignored.

Synchronizer:
- port_out[12], port_out[8] and port_out[7:0] each pass through a 2-flop synchronizer. The synchronized copies are req_s, ack_s and dat_s.
- CPU software rule: write the data nibbles before writing the toggle nibble, in a separate instruction.

TX presenter FSM:
- IDLE: when the TX FIFO is not empty, pop it and load the byte into port_in[7:0]; go to SETUP.
- SETUP: invert port_in[8]; go to WAIT_ACK. The data is therefore stable for one full cycle before the toggle.
- WAIT_ACK: stay until ack_s == port_in[8], then go to IDLE.
- The CPU acknowledges by copying the toggle to port_out[8] after it has read the data.

RX capture (level-based, no FSM):
- Condition: req_s != port_in[12] and the RX FIFO is not full.
- Action in that cycle: push dat_s and invert port_in[12].
- While the RX FIFO is full, no ack is sent. The CPU stalls; nothing is lost or duplicated.

FIFOs:
- Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
- full when the pointers differ only in the MSB; empty when they are equal.
- Push is ignored when full and pop is ignored when empty.
- Simultaneous push and pop when neither full nor empty: both happen and the count is unchanged.
- A push into a full FIFO is refused even if a pop happens in the same cycle.

## Timing
- Reset values (in effect from the cycle after rst is sampled high): port_in = 0, all synchronizer flops = 0, both FIFOs empty, FSM in IDLE, tx_ready = 1 once rst is low, rx_valid = 0, rx_data = 0.
- Reset mid-operation: all in-flight bytes are dropped. The CPU must be reset in the same window; after both resets the toggles compare equal (0 == 0) and no phantom transfer occurs.
- tx_ready = !full and is combinational from FIFO state. rx_valid = !empty.
- TX latency, empty FIFO and IDLE: byte accepted at edge N → popped at N+1 with port_in[7:0] updated → port_in[8] toggles at N+2.
- The next TX byte cannot start until 2 cycles after port_out[8] changes (synchronizer delay), plus IDLE/SETUP.
- RX latency: port_out[12] changes → push and rx_ack toggle at the 3rd edge after the change → rx_valid is high at the 4th edge.
- CPU data rule: port_out[7:0] must be stable at least 1 clk period before port_out[12] changes, and must stay stable until port_in[12] equals the new toggle value.
- At most one byte is outstanding per direction on the port. FIFO depth buffers only the host side.

## Test plan
- Reset: hold rst high for 2 cycles with tx_valid=1 → port_in=0, rx_valid=0, and no push occurs; after release, tx_ready=1.
- TX single byte: push 0xA5 → port_in[7:0]=0xA5 at N+1 and port_in[8]=1 at N+2. The model echoes port_out[8]=1 → FSM returns to IDLE 3 cycles later and port_in[8] stays 1.
- TX burst: push 0x01..0x06 with DEPTH=4 and a slow CPU model → tx_ready drops after 5 accepted bytes (4 in the FIFO, 1 on the port). The CPU sees 0x01..0x06 in order with alternating toggles.
- RX backpressure: the CPU sends 0x10..0x15 with rx_ready=0 → 4 bytes are queued and port_in[12] toggles 4 times, then stalls. Raising rx_ready drains 0x10..0x15 in order, with no loss and no duplicates.
- Simultaneous: continuous TX and RX traffic, including push and pop in the same cycle on a half-full FIFO → counts are unchanged, and both streams arrive in order, byte-exact.
- Mid-operation reset: assert rst during WAIT_ACK with 2 bytes queued, reset the CPU model too → port_in=0 and FIFOs empty; a new byte 0x3C then transfers normally.
